// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared types and default widths for the writeback arbiter
package writeback_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;
    localparam int DEFAULT_FIFO_DEPTH     = 2;
    localparam int DEFAULT_STARVE_LIMIT   = 4;

    typedef enum logic {
        PIPE_PRI    = 1'b0,
        FORCE_DRAIN = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_LONG = 2'd2
    } src_sel_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - MEM/WB, long-unit and register-file port bundle
interface writeback_arbiter_if
    import writeback_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) ();

    logic                      wb_valid;
    logic                      wb_memread;
    logic [REG_ADDR_WIDTH-1:0] wb_destination;
    logic [DATA_WIDTH-1:0]     wb_result;
    logic [DATA_WIDTH-1:0]     wb_loadvalue;
    logic                      wb_stall;

    logic                      lu_valid;
    logic                      lu_ready;
    logic [REG_ADDR_WIDTH-1:0] lu_destination;
    logic [DATA_WIDTH-1:0]     lu_data;

    logic                      rf_write_enable;
    logic [REG_ADDR_WIDTH-1:0] rf_write_address;
    logic [DATA_WIDTH-1:0]     rf_write_data;

    modport master (
        output wb_valid, wb_memread, wb_destination, wb_result, wb_loadvalue,
        output lu_valid, lu_destination, lu_data,
        input  wb_stall, lu_ready,
        input  rf_write_enable, rf_write_address, rf_write_data
    );

    modport slave (
        input  wb_valid, wb_memread, wb_destination, wb_result, wb_loadvalue,
        input  lu_valid, lu_destination, lu_data,
        output wb_stall, lu_ready,
        output rf_write_enable, rf_write_address, rf_write_data
    );

endinterface

// File: rtl/writeback_fifo.sv
// rtl/writeback_fifo.sv - pointer-plus-count buffer for long-unit results
module writeback_fifo
    import writeback_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = DEFAULT_REG_ADDR_WIDTH + DEFAULT_DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_entry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write port arbiter between MEM/WB and the long unit
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int STARVE_LIMIT   = DEFAULT_STARVE_LIMIT
) (
    input logic                clock,
    input logic                reset_n,
    writeback_arbiter_if.slave bus
);

    localparam int ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t                state;
    arb_state_t                next_state;
    src_sel_t                  src_sel;
    logic [CNT_W-1:0]          starve_cnt;
    logic [CNT_W-1:0]          starve_next;

    logic                      pipe_req;
    logic                      lu_req;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [ENTRY_W-1:0]        fifo_head;
    logic [REG_ADDR_WIDTH-1:0] head_dest;
    logic [DATA_WIDTH-1:0]     head_data;
    logic [DATA_WIDTH-1:0]     pipe_data;

    assign pipe_req  = bus.wb_valid && (bus.wb_destination != '0);
    assign lu_req    = !fifo_empty;
    assign pipe_data = bus.wb_memread ? bus.wb_loadvalue : bus.wb_result;
    assign {head_dest, head_data} = fifo_head;

    // Register-0 results are acknowledged but never stored, so every buffered entry is a real write.
    assign bus.lu_ready = !fifo_full;
    assign fifo_push    = bus.lu_valid && bus.lu_ready && (bus.lu_destination != '0);
    assign fifo_pop     = (src_sel == SRC_LONG);
    assign bus.wb_stall = (state == FORCE_DRAIN);

    writeback_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry ({bus.lu_destination, bus.lu_data}),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PIPE_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        next_state  = state;
        src_sel     = SRC_NONE;
        starve_next = starve_cnt;
        case (state)
            PIPE_PRI: begin
                if (pipe_req) begin
                    src_sel = SRC_PIPE;
                end else if (lu_req) begin
                    src_sel = SRC_LONG;
                end
                if (src_sel == SRC_LONG) begin
                    starve_next = '0;
                end else if (lu_req && (starve_cnt < LIMIT)) begin
                    starve_next = starve_cnt + 1'b1;
                end
                if (starve_next == LIMIT) begin
                    next_state = FORCE_DRAIN;
                end
            end
            FORCE_DRAIN: begin
                // The held MEM/WB contents are simply ignored here and retried next cycle.
                if (lu_req) begin
                    src_sel = SRC_LONG;
                end
                starve_next = '0;
                next_state  = PIPE_PRI;
            end
            default: begin
                next_state  = PIPE_PRI;
                starve_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.rf_write_enable  <= 1'b0;
            bus.rf_write_address <= '0;
            bus.rf_write_data    <= '0;
        end else begin
            bus.rf_write_enable <= (src_sel != SRC_NONE);
            case (src_sel)
                SRC_PIPE: begin
                    bus.rf_write_address <= bus.wb_destination;
                    bus.rf_write_data    <= pipe_data;
                end
                SRC_LONG: begin
                    bus.rf_write_address <= head_dest;
                    bus.rf_write_data    <= head_data;
                end
                default: begin
                    bus.rf_write_address <= bus.rf_write_address;
                    bus.rf_write_data    <= bus.rf_write_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } entry_t;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    writeback_arbiter_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    writeback_arbiter #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .FIFO_DEPTH     (DEPTH),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: queue of buffered results, count of denied cycles, pending forced drain.
    entry_t        mq[$];
    int            m_deny;
    bit            m_drain;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    initial begin
        entry_t e;
        bit     pipe;
        bit     accept;
        m_deny = 0; m_drain = 0; exp_we = 0; exp_addr = '0; exp_data = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                chk("model_rst_we", 32'(bus.rf_write_enable), 0);
                chk("model_rst_stall", 32'(bus.wb_stall), 0);
                chk("model_rst_ready", 32'(bus.lu_ready), 1);
                mq.delete();
                m_deny = 0; m_drain = 0; exp_we = 0;
            end else begin
                chk("model_we", 32'(bus.rf_write_enable), 32'(exp_we));
                if (exp_we) begin
                    chk("model_addr", 32'(bus.rf_write_address), 32'(exp_addr));
                    chk("model_data", bus.rf_write_data, exp_data);
                end
                chk("model_stall", 32'(bus.wb_stall), 32'(m_drain));
                chk("model_ready", 32'(bus.lu_ready), 32'(mq.size() < DEPTH));

                pipe   = bus.wb_valid && (bus.wb_destination != 0);
                accept = bus.lu_valid && (mq.size() < DEPTH);
                exp_we = 0;
                if (m_drain) begin
                    m_drain = 0;
                    m_deny  = 0;
                    if (mq.size() > 0) begin
                        e = mq.pop_front();
                        exp_we = 1; exp_addr = e.dest; exp_data = e.data;
                    end
                end else if (pipe) begin
                    exp_we   = 1;
                    exp_addr = bus.wb_destination;
                    exp_data = bus.wb_memread ? bus.wb_loadvalue : bus.wb_result;
                    if (mq.size() > 0) begin
                        if (m_deny < LIMIT) m_deny++;
                        if (m_deny == LIMIT) m_drain = 1;
                    end
                end else if (mq.size() > 0) begin
                    e = mq.pop_front();
                    exp_we = 1; exp_addr = e.dest; exp_data = e.data;
                    m_deny = 0;
                end
                if (accept && (bus.lu_destination != 0)) begin
                    e.dest = bus.lu_destination;
                    e.data = bus.lu_data;
                    mq.push_back(e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        int waited;
        int stale;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.wb_valid = 0; bus.wb_memread = 0; bus.wb_destination = '0;
        bus.wb_result = '0; bus.wb_loadvalue = '0;
        bus.lu_valid = 0; bus.lu_destination = '0; bus.lu_data = '0;
        repeat (3) step();
        chk("reset_we", 32'(bus.rf_write_enable), 0);
        chk("reset_addr", 32'(bus.rf_write_address), 0);
        chk("reset_data", bus.rf_write_data, 0);
        chk("reset_stall", 32'(bus.wb_stall), 0);
        chk("reset_ready", 32'(bus.lu_ready), 1);
        reset_n = 1'b1;
        step();

        // Pipeline-only writes, ALU then load data
        bus.wb_valid = 1; bus.wb_destination = 5; bus.wb_result = 32'h1234; bus.wb_memread = 0;
        step();
        chk("pipe_alu_we", 32'(bus.rf_write_enable), 1);
        chk("pipe_alu_addr", 32'(bus.rf_write_address), 5);
        chk("pipe_alu_data", bus.rf_write_data, 32'h1234);
        bus.wb_memread = 1; bus.wb_loadvalue = 32'hCAFE;
        step();
        chk("pipe_load_we", 32'(bus.rf_write_enable), 1);
        chk("pipe_load_data", bus.rf_write_data, 32'hCAFE);

        bus.wb_destination = 0;
        step();
        chk("r0_pipe_we", 32'(bus.rf_write_enable), 0);
        bus.wb_valid = 0; bus.wb_memread = 0;

        // Idle port: long-unit result lands two cycles after the push
        bus.lu_valid = 1; bus.lu_destination = 7; bus.lu_data = 32'hAAAA;
        step();
        bus.lu_valid = 0;
        chk("drain_first_cycle_we", 32'(bus.rf_write_enable), 0);
        step();
        chk("drain_we", 32'(bus.rf_write_enable), 1);
        chk("drain_addr", 32'(bus.rf_write_address), 7);
        chk("drain_data", bus.rf_write_data, 32'hAAAA);

        // Register-0 long-unit result: accepted, never written
        bus.lu_valid = 1; bus.lu_destination = 0; bus.lu_data = 32'h55;
        chk("r0_lu_ready", 32'(bus.lu_ready), 1);
        step();
        bus.lu_valid = 0;
        step();
        chk("r0_lu_no_write", 32'(bus.rf_write_enable), 0);

        // Full FIFO under continuous pipeline traffic
        bus.wb_valid = 1; bus.wb_destination = 3; bus.wb_result = 32'h30;
        bus.lu_valid = 1; bus.lu_destination = 10; bus.lu_data = 32'h100;
        step();
        bus.lu_destination = 11; bus.lu_data = 32'h101;
        step();
        chk("full_ready", 32'(bus.lu_ready), 0);
        bus.lu_destination = 12; bus.lu_data = 32'h102;
        waited = 0;
        while (!bus.lu_ready && waited < 20) begin
            step();
            waited++;
        end
        chk("full_wait_cycles", 32'(waited), 4);
        step();
        bus.lu_valid = 0; bus.wb_valid = 0;
        repeat (4) step();
        chk("full_drained_ready", 32'(bus.lu_ready), 1);

        // Starvation: four denied cycles, one stall, held pipeline write retried
        bus.wb_valid = 1; bus.wb_destination = 9; bus.wb_result = 32'h900;
        bus.lu_valid = 1; bus.lu_destination = 20; bus.lu_data = 32'h2000;
        step();
        bus.lu_valid = 0;
        chk("starve_pipe_addr", 32'(bus.rf_write_address), 9);
        chk("starve_pipe_data", bus.rf_write_data, 32'h900);
        for (int k = 1; k <= 4; k++) begin
            bus.wb_result = 32'h900 + 32'(k);
            step();
            chk("starve_stall", 32'(bus.wb_stall), 32'(k == 4));
        end
        chk("starve_last_pipe_data", bus.rf_write_data, 32'h904);
        bus.wb_result = 32'h905;
        step();
        chk("forced_we", 32'(bus.rf_write_enable), 1);
        chk("forced_addr", 32'(bus.rf_write_address), 20);
        chk("forced_data", bus.rf_write_data, 32'h2000);
        chk("forced_stall_cleared", 32'(bus.wb_stall), 0);
        step();
        chk("retry_we", 32'(bus.rf_write_enable), 1);
        chk("retry_addr", 32'(bus.rf_write_address), 9);
        chk("retry_data", bus.rf_write_data, 32'h905);
        bus.wb_valid = 0;
        step();

        // Reset while two results are buffered and a write is on the port
        bus.wb_valid = 1; bus.wb_destination = 4; bus.wb_result = 32'h44;
        bus.lu_valid = 1; bus.lu_destination = 21; bus.lu_data = 32'h11;
        step();
        bus.lu_destination = 22; bus.lu_data = 32'h22;
        step();
        bus.lu_valid = 0;
        chk("pre_reset_we", 32'(bus.rf_write_enable), 1);
        chk("pre_reset_ready", 32'(bus.lu_ready), 0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(bus.rf_write_enable), 0);
        chk("async_rst_addr", 32'(bus.rf_write_address), 0);
        chk("async_rst_data", bus.rf_write_data, 0);
        chk("async_rst_stall", 32'(bus.wb_stall), 0);
        chk("async_rst_ready", 32'(bus.lu_ready), 1);
        bus.wb_valid = 0;
        step();
        step();
        reset_n = 1'b1;
        stale = 0;
        repeat (8) begin
            step();
            if (bus.rf_write_enable) stale++;
        end
        chk("no_stale_writes", 32'(stale), 0);
        chk("post_reset_ready", 32'(bus.lu_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
